spi_port_arb: RTL and testbench

//  Arbitrates the SPI block's shared CBUSP slave port between the config requester and four memory-window requesters.

---
 rtl/spi_port_arb.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_port_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_port_arb.sv
// ---------------------------------------------------------------------------
// spi_port_arb
//   Arbiter for the SPI block's shared CBUSP slave port. One config requester
//   and four memory-window requesters compete for the port. The winner keeps a
//   one-hot grant until it signals 'done'. A watchdog reclaims the port if the
//   owner never finishes. The grant drives the slave-port mux in front of the
//   SPI block.
//
// Parameters
//   TO_W     width of the watchdog counter
//   TO_MAX   BUSY cycles without 'done' before a forced release (1..2^TO_W-1)
//
// Ports
//   clk       system clock
//   rst_n     synchronous active-low reset
//   cfg_req   config-port request (level, held until granted)
//   mm_req    memory-port requests [3:0] (level, held until granted)
//   arb_mode  arbitration mode, sampled only when arbitrating in IDLE
//               00 fixed priority  cfg > mm0 > mm1 > mm2 > mm3
//               01 round-robin over all five requesters
//               10 cfg only (memory requests masked)
//               11 cfg strict-highest, mm0..mm3 round-robin
//   done      one-cycle pulse: the current owner's transaction finished
//   gnt       one-hot grant {cfg,mm3,mm2,mm1,mm0}, zero when idle
//   busy      port currently owned
//   owner     index of current/last owner (0-3 = mm, 4 = cfg)
//   to_irq    one-cycle pulse on a watchdog release
//   to_owner  owner index captured at the last watchdog release
// ---------------------------------------------------------------------------
module spi_port_arb #(
  parameter int TO_W   = 8,
  parameter int TO_MAX = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_req,
  input  logic [3:0] mm_req,
  input  logic [1:0] arb_mode,
  input  logic       done,
  output logic [4:0] gnt,
  output logic       busy,
  output logic [2:0] owner,
  output logic       to_irq,
  output logic [2:0] to_owner
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] MODE_FIXED = 2'b00;
  localparam logic [1:0] MODE_RR5   = 2'b01;
  localparam logic [1:0] MODE_CFG   = 2'b10;
  localparam logic [1:0] MODE_MMRR  = 2'b11;

  localparam logic [2:0] CFG_IDX = 3'd4;

  state_t          state_reg;
  logic [4:0]      gnt_reg;
  logic            busy_reg;
  logic [2:0]      owner_reg;
  logic            to_irq_reg;
  logic [2:0]      to_owner_reg;
  logic [2:0]      rr_ptr_reg;
  logic [TO_W-1:0] wd_reg;
  // Mode in force for the current grant; the pointer update at release must
  // follow the mode that produced the grant, not whatever arb_mode is now.
  logic [1:0]      mode_reg;

  logic [4:0] req_vec;
  logic       win_valid;
  logic [2:0] win_idx;
  logic       wd_expired;
  logic       release_now;
  logic [2:0] rr_ptr_next;

  assign req_vec = {cfg_req, mm_req};

  // -------------------------------------------------------------------------
  // Round-robin search orders. rr5_idx[k] is the k-th candidate when scanning
  // all five requesters from rr_ptr; rr4_idx[k] the same over mm0..mm3 only.
  // A pointer of 4 (left over from mode 01) restarts the mm-only scan at mm0.
  // -------------------------------------------------------------------------
  logic [2:0] rr5_idx [5];
  logic [1:0] rr4_idx [4];
  logic [1:0] rr4_start;

  assign rr4_start = (rr_ptr_reg > 3'd3) ? 2'd0 : rr_ptr_reg[1:0];

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_rr5
      logic [3:0] sum5;
      assign sum5        = {1'b0, rr_ptr_reg} + 4'(gi);
      assign rr5_idx[gi] = (sum5 >= 4'd5) ? 3'(sum5 - 4'd5) : sum5[2:0];
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_rr4
      assign rr4_idx[gi] = rr4_start + 2'(gi);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Winner selection for the IDLE arbitration cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 3'd0;
    unique case (arb_mode)
      MODE_FIXED: begin
        if (cfg_req) begin
          win_valid = 1'b1;
          win_idx   = CFG_IDX;
        end else begin
          // Scan downwards so the lowest-numbered mm request wins.
          for (int i = 3; i >= 0; i--) begin
            if (mm_req[i]) begin
              win_valid = 1'b1;
              win_idx   = 3'(i);
            end
          end
        end
      end
      MODE_RR5: begin
        for (int i = 0; i < 5; i++) begin
          if (!win_valid && req_vec[rr5_idx[i]]) begin
            win_valid = 1'b1;
            win_idx   = rr5_idx[i];
          end
        end
      end
      MODE_CFG: begin
        if (cfg_req) begin
          win_valid = 1'b1;
          win_idx   = CFG_IDX;
        end
      end
      MODE_MMRR: begin
        if (cfg_req) begin
          win_valid = 1'b1;
          win_idx   = CFG_IDX;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (!win_valid && mm_req[rr4_idx[i]]) begin
              win_valid = 1'b1;
              win_idx   = {1'b0, rr4_idx[i]};
            end
          end
        end
      end
      default: begin
        win_valid = 1'b0;
        win_idx   = 3'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Release handling: normal completion or watchdog expiry, and the pointer
  // value that the next round-robin search starts from.
  // -------------------------------------------------------------------------
  assign wd_expired  = (wd_reg == TO_W'(TO_MAX - 1));
  assign release_now = done || wd_expired;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    unique case (mode_reg)
      MODE_RR5: begin
        rr_ptr_next = (owner_reg == CFG_IDX) ? 3'd0 : owner_reg + 3'd1;
      end
      MODE_MMRR: begin
        // A cfg owner does not disturb the mm rotation.
        if (owner_reg != CFG_IDX) begin
          rr_ptr_next = {1'b0, owner_reg[1:0] + 2'd1};
        end
      end
      default: rr_ptr_next = rr_ptr_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // Two-state FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= 5'b0;
      busy_reg     <= 1'b0;
      owner_reg    <= 3'd0;
      to_irq_reg   <= 1'b0;
      to_owner_reg <= 3'd0;
      rr_ptr_reg   <= 3'd0;
      wd_reg       <= '0;
      mode_reg     <= MODE_FIXED;
    end else begin
      to_irq_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (win_valid) begin
            gnt_reg   <= 5'b00001 << win_idx;
            owner_reg <= win_idx;
            busy_reg  <= 1'b1;
            wd_reg    <= '0;
            mode_reg  <= arb_mode;
            state_reg <= BUSY;
          end else begin
            gnt_reg <= 5'b0;
          end
        end
        BUSY: begin
          if (release_now) begin
            gnt_reg    <= 5'b0;
            busy_reg   <= 1'b0;
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= IDLE;
            // A 'done' landing on the expiry cycle counts as a normal finish.
            if (!done) begin
              to_irq_reg   <= 1'b1;
              to_owner_reg <= owner_reg;
            end
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 5'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = gnt_reg;
  assign busy     = busy_reg;
  assign owner    = owner_reg;
  assign to_irq   = to_irq_reg;
  assign to_owner = to_owner_reg;

endmodule

// File: tb/tb_spi_port_arb.sv
// ---------------------------------------------------------------------------
// tb_spi_port_arb
//   Self-checking bench for spi_port_arb. Expected grants are queued as the
//   stimulus is applied; a monitor pops and compares them each time a new
//   grant appears. Timing-sensitive points are checked directly in the
//   stimulus sequence.
// ---------------------------------------------------------------------------
module tb_spi_port_arb;

  localparam int TO_W   = 8;
  localparam int TO_MAX = 200;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       cfg_req  = 1'b0;
  logic [3:0] mm_req   = 4'b0;
  logic [1:0] arb_mode = 2'b00;
  logic       done     = 1'b0;
  logic [4:0] gnt;
  logic       busy;
  logic [2:0] owner;
  logic       to_irq;
  logic [2:0] to_owner;

  spi_port_arb #(.TO_W(TO_W), .TO_MAX(TO_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_req  (cfg_req),
    .mm_req   (mm_req),
    .arb_mode (arb_mode),
    .done     (done),
    .gnt      (gnt),
    .busy     (busy),
    .owner    (owner),
    .to_irq   (to_irq),
    .to_owner (to_owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] oh2idx(input logic [4:0] oh);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 5; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Scoreboard of expected grant vectors, in order.
  logic [4:0] sb_q[$];
  logic [4:0] prev_gnt = 5'b0;
  logic [4:0] exp_gnt;

  always @(negedge clk) begin
    check_val("gnt_onehot0", 32'($onehot0(gnt)), 1);
    check_val("busy_vs_gnt", 32'(busy), 32'(|gnt));
    if (gnt != 5'b0 && prev_gnt == 5'b0) begin
      check_val("sb_pending", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_gnt = sb_q.pop_front();
        check_val("sb_gnt", 32'(gnt), 32'(exp_gnt));
        check_val("sb_owner", 32'(owner), oh2idx(exp_gnt));
        $display("grant gnt=%b owner=%0d expected=%b cycle=%0d", gnt, owner, exp_gnt, cyc);
      end
    end
    prev_gnt = gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    cfg_req = 1'b0;
    mm_req  = 4'b0;
    done    = 1'b0;
    tick();
    tick();
    check_val("rst_gnt", 32'(gnt), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_owner", 32'(owner), 0);
    check_val("rst_to_irq", 32'(to_irq), 0);
    check_val("rst_to_owner", 32'(to_owner), 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (gnt == 5'b0 && n < 400) begin
      tick();
      n++;
    end
    check_val("grant_seen", 32'(gnt != 5'b0), 1);
  endtask

  // Wait for a grant, then finish the transaction 'hold' cycles after it.
  task automatic serve(input int hold, input bit raise_cfg, input bit drop_cfg,
                       input bit drop_all, output int gc);
    int n;
    wait_grant(n);
    gc = cyc;
    if (raise_cfg) cfg_req = 1'b1;
    if (drop_cfg && gnt[4]) cfg_req = 1'b0;
    if (drop_all) begin
      cfg_req = 1'b0;
      mm_req  = 4'b0;
    end
    repeat (hold - 1) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("release", 32'(gnt), 0);
  endtask

  initial begin
    int n, gc, last, bad;

    // ---- 1: fixed priority -------------------------------------------------
    do_reset();
    arb_mode = 2'b00;
    cfg_req  = 1'b1;
    mm_req   = 4'b0101;
    sb_q.push_back(5'b10000);
    tick();
    check_val("t1_latency", 32'(gnt), 32'h10);
    cfg_req = 1'b0;
    done    = 1'b1;
    sb_q.push_back(5'b00001);
    tick();
    done = 1'b0;
    check_val("t1_release", 32'(gnt), 0);
    tick();
    check_val("t1_next", 32'(gnt), 32'h01);
    mm_req = 4'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("t1_done", 32'(gnt), 0);
    done = 1'b1;                       // done while idle must be ignored
    tick();
    done = 1'b0;
    check_val("t1_idle_done_gnt", 32'(gnt), 0);
    check_val("t1_idle_done_owner", 32'(owner), 0);

    // ---- 2: round-robin over five ------------------------------------------
    do_reset();
    arb_mode = 2'b01;
    cfg_req  = 1'b1;
    mm_req   = 4'hF;
    sb_q.push_back(5'b00001);
    sb_q.push_back(5'b00010);
    sb_q.push_back(5'b00100);
    sb_q.push_back(5'b01000);
    sb_q.push_back(5'b10000);
    sb_q.push_back(5'b00001);
    last = 0;
    for (int k = 0; k < 6; k++) begin
      serve(3, 1'b0, 1'b0, k == 5, gc);
      if (k > 0) check_val("t2_spacing", 32'(gc - last), 4);
      last = gc;
    end

    // ---- 3: cfg strict-highest, mm round-robin -----------------------------
    do_reset();
    arb_mode = 2'b11;
    mm_req   = 4'hF;
    sb_q.push_back(5'b00001);
    sb_q.push_back(5'b00010);
    sb_q.push_back(5'b10000);
    sb_q.push_back(5'b00100);
    sb_q.push_back(5'b01000);
    sb_q.push_back(5'b00001);
    last = 0;
    for (int k = 0; k < 6; k++) begin
      serve(3, k == 1, 1'b1, k == 5, gc);
      if (k == 2) check_val("t3_cfg_next_idle", 32'(gc - last), 4);
      last = gc;
    end

    // ---- 4: watchdog -------------------------------------------------------
    do_reset();
    arb_mode = 2'b00;
    mm_req   = 4'b1100;
    sb_q.push_back(5'b00100);
    sb_q.push_back(5'b01000);
    wait_grant(n);
    check_val("t4_grant_mm2", 32'(gnt), 32'h04);
    mm_req = 4'b1000;
    n = 0;
    while (gnt != 5'b0 && n < 400) begin
      tick();
      n++;
    end
    check_val("t4_wd_cycles", 32'(n), TO_MAX);
    check_val("t4_to_irq", 32'(to_irq), 1);
    check_val("t4_to_owner", 32'(to_owner), 2);
    tick();
    check_val("t4_irq_pulse", 32'(to_irq), 0);
    check_val("t4_next_grant", 32'(gnt), 32'h08);
    mm_req = 4'b0;
    repeat (TO_MAX - 1) tick();
    check_val("t4_hold_before_expiry", 32'(gnt), 32'h08);
    done = 1'b1;                       // done lands on the expiry edge
    tick();
    done = 1'b0;
    check_val("t4_expiry_done_gnt", 32'(gnt), 0);
    check_val("t4_expiry_done_irq", 32'(to_irq), 0);
    check_val("t4_to_owner_kept", 32'(to_owner), 2);

    // ---- 5: cfg-only mode masks memory requests ----------------------------
    do_reset();
    arb_mode = 2'b10;
    mm_req   = 4'hF;
    bad      = 0;
    repeat (50) begin
      tick();
      if (gnt != 5'b0) bad++;
    end
    check_val("t5_masked", 32'(bad), 0);
    cfg_req = 1'b1;
    sb_q.push_back(5'b10000);
    tick();
    check_val("t5_cfg_grant", 32'(gnt), 32'h10);
    cfg_req = 1'b0;
    mm_req  = 4'b0;
    done    = 1'b1;
    tick();
    done = 1'b0;

    // ---- 6: reset while busy, with done and watchdog on the same edge ------
    do_reset();
    arb_mode = 2'b01;
    mm_req   = 4'b0001;
    sb_q.push_back(5'b00001);
    serve(3, 1'b0, 1'b0, 1'b1, gc);
    mm_req = 4'b0010;
    sb_q.push_back(5'b00010);
    wait_grant(n);
    check_val("t6_owner_mm1", 32'(owner), 1);
    repeat (TO_MAX - 1) tick();
    done  = 1'b1;
    rst_n = 1'b0;
    tick();
    done = 1'b0;
    check_val("t6_gnt", 32'(gnt), 0);
    check_val("t6_busy", 32'(busy), 0);
    check_val("t6_to_irq", 32'(to_irq), 0);
    check_val("t6_owner", 32'(owner), 0);
    rst_n   = 1'b1;
    cfg_req = 1'b1;
    mm_req  = 4'hF;
    sb_q.push_back(5'b00001);          // pointer back at 0 after reset
    wait_grant(n);
    check_val("t6_rr_reset", 32'(owner), 0);
    cfg_req = 1'b0;
    mm_req  = 4'b0;
    done    = 1'b1;
    tick();
    done = 1'b0;
    tick();

    check_val("sb_drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
